// File: rtl/snail_pattern_fsm.sv
// Serial pattern detector: matches a run-time selectable bit pattern of up to
// w_pattern bits in a strobe-gated stream, with match pulse, saturating count and prefix progress.
module snail_pattern_fsm #(
    parameter  int w_pattern = 4,
    parameter  int w_count   = 8,
    localparam int w_len     = $clog2(w_pattern + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 a,
    input  logic [w_pattern-1:0] pattern,
    input  logic [w_len-1:0]     pattern_len,
    input  logic                 overlap,
    output logic                 match,
    output logic [w_count-1:0]   match_count,
    output logic [w_len-1:0]     progress
);

    logic [w_pattern-1:0] h_q, h_d;
    logic [w_len-1:0]     fill_q, fill_d;
    logic                 match_q, match_d;
    logic [w_count-1:0]   count_q, count_d;
    logic [w_len-1:0]     progress_q, progress_d;

    logic [w_len-1:0]     len_eff;
    logic [w_pattern-1:0] h_shift;
    logic [w_len-1:0]     fill_inc;
    logic [w_pattern-1:0] mask_len;
    logic                 hit;
    logic [w_len-1:0]     prog_new;
    logic [w_pattern-1:0] mask_k;
    logic [w_pattern-1:0] pat_shift;

    always_comb begin
        if (pattern_len == '0) begin
            len_eff = w_len'(1);
        end else if (pattern_len > w_len'(w_pattern)) begin
            len_eff = w_len'(w_pattern);
        end else begin
            len_eff = pattern_len;
        end

        h_shift  = {h_q[w_pattern-2:0], a};
        fill_inc = (fill_q == w_len'(w_pattern)) ? fill_q : fill_q + 1'b1;
        mask_len = {w_pattern{1'b1}} >> (w_pattern - int'(len_eff));
        hit      = (fill_inc >= len_eff) && (((h_shift ^ pattern) & mask_len) == '0);

        // Longest k with the k newest bits equal to the k-bit pattern prefix;
        // ascending scan so the last qualifying k wins.
        prog_new  = '0;
        mask_k    = '0;
        pat_shift = '0;
        for (int k = 1; k <= w_pattern; k++) begin
            mask_k    = {w_pattern{1'b1}} >> (w_pattern - k);
            pat_shift = pattern >> (int'(len_eff) - k);
            if ((k <= int'(len_eff)) && (k <= int'(fill_inc)) &&
                (((h_shift ^ pat_shift) & mask_k) == '0)) begin
                prog_new = w_len'(k);
            end
        end
    end

    always_comb begin
        h_d        = h_q;
        fill_d     = fill_q;
        match_d    = 1'b0;
        count_d    = count_q;
        progress_d = progress_q;

        if (clear) begin
            h_d        = '0;
            fill_d     = '0;
            count_d    = '0;
            progress_d = '0;
        end else if (en) begin
            h_d        = h_shift;
            fill_d     = fill_inc;
            progress_d = prog_new;
            if (hit) begin
                match_d = 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
                // Non-overlapping mode restarts from scratch so the completing bit is not reused.
                if (!overlap) begin
                    fill_d     = '0;
                    progress_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q        <= '0;
            fill_q     <= '0;
            match_q    <= 1'b0;
            count_q    <= '0;
            progress_q <= '0;
        end else begin
            h_q        <= h_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            count_q    <= count_d;
            progress_q <= progress_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign progress    = progress_q;

endmodule
